// File: rtl/track_box_ctrl.sv
// Per-frame mask bounding-box accumulator with SEARCH/ACQUIRE/LOCKED/COAST tracking FSM.
// Latency: frame_done and box/state update 2 cycles after the frame-end pixel; no backpressure.
module track_box_ctrl #(
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int MIN_PIXELS  = 64,
    parameter int LOCK_FRAMES = 2,
    parameter int LOST_FRAMES = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        binary_in,
    input  logic [11:0] h_cnt,
    input  logic [10:0] v_cnt,
    output logic        box_valid,
    output logic [11:0] box_x0,
    output logic [11:0] box_x1,
    output logic [10:0] box_y0,
    output logic [10:0] box_y1,
    output logic        frame_done,
    output logic [1:0]  track_state
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        COAST   = 2'd3
    } state_t;

    logic        qual, is_start, is_end, acc_en, eval_d;
    logic        armed_q, armed_d, seen_q, seen_d, seen_b;
    logic [16:0] cnt_q, cnt_d, cnt_b;
    logic [11:0] xmin_q, xmin_d, xmin_b, xmax_q, xmax_d, xmax_b;
    logic [10:0] ymin_q, ymin_d, ymin_b, ymax_q, ymax_d, ymax_b;

    logic        eval_q;
    logic [16:0] snap_cnt_q;
    logic [45:0] snap_box_q;
    logic        hit;

    state_t      state_q;
    logic [7:0]  run_q, miss_q;
    logic [45:0] box_q;
    logic        box_valid_q, frame_done_q;

    assign qual     = pix_valid && (h_cnt < 12'(IMG_WIDTH)) && (v_cnt < 11'(IMG_HEIGHT));
    assign is_start = qual && (h_cnt == 12'd0) && (v_cnt == 11'd0);
    assign is_end   = qual && (h_cnt == 12'(IMG_WIDTH - 1)) && (v_cnt == 11'(IMG_HEIGHT - 1));
    assign acc_en   = qual && (armed_q || is_start);
    assign eval_d   = acc_en && is_end;

    // A frame start restarts from a cleared base so the start pixel itself accumulates.
    always_comb begin
        cnt_b   = is_start ? 17'd0 : cnt_q;
        xmin_b  = is_start ? 12'd0 : xmin_q;
        xmax_b  = is_start ? 12'd0 : xmax_q;
        ymin_b  = is_start ? 11'd0 : ymin_q;
        ymax_b  = is_start ? 11'd0 : ymax_q;
        seen_b  = is_start ? 1'b0  : seen_q;
        cnt_d   = cnt_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        seen_d  = seen_q;
        armed_d = armed_q;
        if (acc_en) begin
            cnt_d   = cnt_b;
            xmin_d  = xmin_b;
            xmax_d  = xmax_b;
            ymin_d  = ymin_b;
            ymax_d  = ymax_b;
            seen_d  = seen_b;
            armed_d = !is_end;
            if (binary_in) begin
                if (cnt_b != 17'h1FFFF) begin
                    cnt_d = cnt_b + 17'd1;
                end
                seen_d = 1'b1;
                if (!seen_b) begin
                    xmin_d = h_cnt;
                    xmax_d = h_cnt;
                    ymin_d = v_cnt;
                    ymax_d = v_cnt;
                end else begin
                    if (h_cnt < xmin_b) xmin_d = h_cnt;
                    if (h_cnt > xmax_b) xmax_d = h_cnt;
                    if (v_cnt < ymin_b) ymin_d = v_cnt;
                    if (v_cnt > ymax_b) ymax_d = v_cnt;
                end
            end
        end
    end

    // Snapshot decouples the pending evaluation from a new frame starting right behind it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            armed_q    <= 1'b0;
            seen_q     <= 1'b0;
            cnt_q      <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            eval_q     <= 1'b0;
            snap_cnt_q <= '0;
            snap_box_q <= '0;
        end else begin
            armed_q <= armed_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            eval_q  <= eval_d;
            if (eval_d) begin
                snap_cnt_q <= cnt_d;
                snap_box_q <= {xmin_d, xmax_d, ymin_d, ymax_d};
            end
        end
    end

    assign hit = (snap_cnt_q >= 17'(MIN_PIXELS));

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            miss_q       <= '0;
            box_q        <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= eval_q;
            if (eval_q) begin
                case (state_q)
                    SEARCH: begin
                        if (hit) begin
                            if (LOCK_FRAMES <= 1) begin
                                state_q     <= LOCKED;
                                box_q       <= snap_box_q;
                                box_valid_q <= 1'b1;
                            end else begin
                                state_q <= ACQUIRE;
                                run_q   <= 8'd1;
                            end
                        end
                    end
                    ACQUIRE: begin
                        if (!hit) begin
                            state_q <= SEARCH;
                            run_q   <= '0;
                        end else if ((run_q + 8'd1) >= 8'(LOCK_FRAMES)) begin
                            state_q     <= LOCKED;
                            run_q       <= '0;
                            box_q       <= snap_box_q;
                            box_valid_q <= 1'b1;
                        end else begin
                            run_q <= run_q + 8'd1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            box_q <= snap_box_q;
                        end else if (LOST_FRAMES <= 1) begin
                            state_q     <= SEARCH;
                            box_valid_q <= 1'b0;
                        end else begin
                            state_q <= COAST;
                            miss_q  <= 8'd1;
                        end
                    end
                    default: begin
                        if (hit) begin
                            state_q <= LOCKED;
                            miss_q  <= '0;
                            box_q   <= snap_box_q;
                        end else if ((miss_q + 8'd1) >= 8'(LOST_FRAMES)) begin
                            state_q     <= SEARCH;
                            miss_q      <= '0;
                            box_valid_q <= 1'b0;
                        end else begin
                            miss_q <= miss_q + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign track_state = state_q;
    assign box_valid   = box_valid_q;
    assign frame_done  = frame_done_q;
    assign {box_x0, box_x1, box_y0, box_y1} = box_q;

endmodule

// File: tb/tb_track_box_ctrl.sv
// Bench for track_box_ctrl: sparse raster frames, expected evaluation results queued per frame end.
module tb_track_box_ctrl;

    localparam int W = 320;
    localparam int H = 240;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        binary_in = 1'b0;
    logic [11:0] h_cnt = '0;
    logic [10:0] v_cnt = '0;
    logic        box_valid;
    logic [11:0] box_x0, box_x1;
    logic [10:0] box_y0, box_y1;
    logic        frame_done;
    logic [1:0]  track_state;

    track_box_ctrl dut (
        .pclk(pclk), .rst(rst), .pix_valid(pix_valid), .binary_in(binary_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .box_valid(box_valid),
        .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
        .frame_done(frame_done), .track_state(track_state)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [1:0]  st;
        logic        vld;
        logic [11:0] x0, x1;
        logic [10:0] y0, y1;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;
    logic fd_prev = 1'b0;
    logic [45:0] box_prev = '0;

    always @(posedge pclk) cyc++;

    always @(posedge pclk) begin
        #1;
        if (frame_done === 1'b1) begin
            fd_count++;
            checks++;
            if (fd_prev === 1'b1) begin
                errors++;
                $display("FAIL frame_done_width: high on consecutive cycles at cyc %0d, required one-cycle pulse", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done: pulse at cyc %0d with no evaluation pending", cyc);
            end else begin
                em = sb.pop_front();
                if (track_state !== em.st || box_valid !== em.vld || box_x0 !== em.x0 || box_x1 !== em.x1 ||
                    box_y0 !== em.y0 || box_y1 !== em.y1 || cyc !== em.at) begin
                    errors++;
                    $display("FAIL eval_result: got st=%0d vld=%0b box=(%0d,%0d,%0d,%0d) cyc=%0d, required st=%0d vld=%0b box=(%0d,%0d,%0d,%0d) cyc=%0d",
                             track_state, box_valid, box_x0, box_x1, box_y0, box_y1, cyc,
                             em.st, em.vld, em.x0, em.x1, em.y0, em.y1, em.at);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            checks++;
            errors++;
            $display("FAIL frame_done_missing: none by cyc %0d, required at cyc %0d", cyc, sb[0].at);
            void'(sb.pop_front());
        end
        if (rst === 1'b0 && frame_done === 1'b0) begin
            checks++;
            if ({box_x0, box_x1, box_y0, box_y1} !== box_prev) begin
                errors++;
                $display("FAIL box_stable: box changed to (%0d,%0d,%0d,%0d) outside frame_done at cyc %0d, required unchanged",
                         box_x0, box_x1, box_y0, box_y1, cyc);
            end
        end
        box_prev = {box_x0, box_x1, box_y0, box_y1};
        fd_prev  = frame_done;
    end

    task automatic pix(input logic v, input logic b, input int x, input int y);
        @(negedge pclk);
        pix_valid = v;
        binary_in = b;
        h_cnt     = 12'(x);
        v_cnt     = 11'(y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 0, 0);
    endtask

    // Start pixel, ignored pixels, up to n mask pixels raster-scanning the rect, end pixel.
    task automatic frame(input int rx0, input int rx1, input int ry0, input int ry1, input int n,
                         input logic end_b, input logic [1:0] est, input logic evld,
                         input int bx0, input int bx1, input int by0, input int by1);
        exp_t e;
        int k;
        k = 0;
        pix(1'b1, 1'b0, 0, 0);
        pix(1'b0, 1'b1, 5, 5);
        pix(1'b1, 1'b1, W, 5);
        pix(1'b1, 1'b1, 5, H);
        for (int y = ry0; y <= ry1; y++)
            for (int x = rx0; x <= rx1; x++)
                if (k < n) begin
                    pix(1'b1, 1'b1, x, y);
                    k++;
                end
        pix(1'b1, end_b, W - 1, H - 1);
        e.st = est; e.vld = evld;
        e.x0 = 12'(bx0); e.x1 = 12'(bx1); e.y0 = 11'(by0); e.y1 = 11'(by1);
        e.at = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic empty_frame(input logic [1:0] est, input logic evld,
                               input int bx0, input int bx1, input int by0, input int by1);
        frame(1, 0, 1, 0, 0, 1'b0, est, evld, bx0, bx1, by0, by1);
    endtask

    task automatic test_reset;
        int fd0;
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if (track_state !== 2'd0 || box_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: st=%0d vld=%0b fd=%0b, required 0 0 0", track_state, box_valid, frame_done);
        end
        checks++;
        if ({box_x0, box_x1, box_y0, box_y1} !== 46'd0) begin
            errors++;
            $display("FAIL reset_box: box=(%0d,%0d,%0d,%0d), required all 0", box_x0, box_x1, box_y0, box_y1);
        end
        rst = 1'b0;
        fd0 = fd_count;
        pix(1'b1, 1'b0, W - 1, H - 1);
        idle(5);
        checks++;
        if (fd_count !== fd0) begin
            errors++;
            $display("FAIL unarmed_end: %0d frame_done pulses, required 0", fd_count - fd0);
        end
        empty_frame(2'd0, 1'b0, 0, 0, 0, 0);
        empty_frame(2'd0, 1'b0, 0, 0, 0, 0);
        idle(5);
        checks++;
        if (fd_count !== fd0 + 2) begin
            errors++;
            $display("FAIL reset_two_frames: %0d frame_done pulses, required 2", fd_count - fd0);
        end
    endtask

    task automatic test_lock;
        frame(100, 109, 50, 59, 100, 1'b0, 2'd1, 1'b0, 0, 0, 0, 0);
        frame(100, 109, 50, 59, 100, 1'b0, 2'd2, 1'b1, 100, 109, 50, 59);
    endtask

    task automatic test_coast_drop;
        empty_frame(2'd3, 1'b1, 100, 109, 50, 59);
        empty_frame(2'd3, 1'b1, 100, 109, 50, 59);
        empty_frame(2'd3, 1'b1, 100, 109, 50, 59);
        empty_frame(2'd0, 1'b0, 100, 109, 50, 59);
    endtask

    task automatic test_threshold;
        frame(10, 18, 20, 26, 63, 1'b0, 2'd0, 1'b0, 100, 109, 50, 59);
        frame(10, 18, 20, 26, 63, 1'b1, 2'd1, 1'b0, 100, 109, 50, 59);
        frame(10, 18, 20, 26, 63, 1'b1, 2'd2, 1'b1, 10, 319, 20, 239);
    endtask

    task automatic test_recover_move;
        empty_frame(2'd3, 1'b1, 10, 319, 20, 239);
        empty_frame(2'd3, 1'b1, 10, 319, 20, 239);
        frame(200, 209, 50, 59, 100, 1'b0, 2'd2, 1'b1, 200, 209, 50, 59);
        empty_frame(2'd3, 1'b1, 200, 209, 50, 59);
        empty_frame(2'd3, 1'b1, 200, 209, 50, 59);
        empty_frame(2'd3, 1'b1, 200, 209, 50, 59);
        empty_frame(2'd0, 1'b0, 200, 209, 50, 59);
    endtask

    task automatic test_interrupted;
        int fd0;
        frame(100, 109, 50, 59, 100, 1'b0, 2'd1, 1'b0, 200, 209, 50, 59);
        idle(4);
        fd0 = fd_count;
        pix(1'b1, 1'b0, 0, 0);
        for (int y = 100; y <= 109; y++)
            for (int x = 100; x <= 109; x++) pix(1'b1, 1'b1, x, y);
        pix(1'b1, 1'b0, 0, 120);
        @(negedge pclk);
        rst = 1'b1;
        pix_valid = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        pix(1'b1, 1'b0, W - 1, H - 1);
        idle(5);
        checks++;
        if (fd_count !== fd0 || track_state !== 2'd0 || box_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: pulses=%0d st=%0d vld=%0b, required 0 0 0", fd_count - fd0, track_state, box_valid);
        end
        fd0 = fd_count;
        pix(1'b1, 1'b0, 0, 0);
        for (int y = 50; y <= 59; y++)
            for (int x = 100; x <= 109; x++) pix(1'b1, 1'b1, x, y);
        pix(1'b1, 1'b0, 7, 100);
        empty_frame(2'd0, 1'b0, 0, 0, 0, 0);
        idle(5);
        checks++;
        if (fd_count !== fd0 + 1) begin
            errors++;
            $display("FAIL short_frame: %0d frame_done pulses, required 1", fd_count - fd0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_coast_drop();
        test_threshold();
        test_recover_move();
        test_interrupted();
        idle(6);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d evaluations outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/track_box_ctrl.md
# track_box_ctrl

Frame-level tracking controller for the colour-detect pipeline. Monitors the per-pixel binary mask alongside the raster counters, accumulates a bounding box and pixel count for each frame, and runs a lock/coast state machine. Drives the overlay renderer with a stable, hysteresis-filtered box: coordinates plus a valid flag that tells the renderer whether to draw. Sits beside the renderer in the pclk domain, fed by the same mask and counter signals.

## Interface
- IMG_WIDTH, 320, active pixels per line
- IMG_HEIGHT, 240, active lines per frame
- MIN_PIXELS, 64, mask pixels per frame needed to count the frame as a hit
- LOCK_FRAMES, 2, consecutive hit frames needed to enter LOCKED (≥1)
- LOST_FRAMES, 4, consecutive miss frames in COAST before dropping to SEARCH (≥1)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  active-video qualifier for binary_in/h_cnt/v_cnt
- binary_in  in  1  colour-match mask bit for the current pixel
- h_cnt  in  12  column of current pixel
- v_cnt  in  11  line of current pixel
- box_valid  out  1  renderer should draw the box
- box_x0, box_x1  out  12 each  left/right column, inclusive
- box_y0, box_y1  out  11 each  top/bottom line, inclusive
- frame_done  out  1  one-cycle pulse when frame statistics are evaluated
- track_state  out  2  SEARCH=0, ACQUIRE=1, LOCKED=2, COAST=3

## Operation
- **Qualified pixel:** pix_valid=1, h_cnt<IMG_WIDTH and v_cnt<IMG_HEIGHT. All other cycles are ignored entirely.
- **Frame start:** a qualified pixel at (0,0). It sets `armed`, clears the accumulators, and is itself accumulated.
- **Accumulators (only while armed):**
  - pix_cnt: 17 bits, saturates at 131071.
  - xmin/xmax, ymin/ymax.
  - The first mask pixel of a frame loads all four bounds directly. Later mask pixels update them with min/max.
- **Frame end:** a qualified pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) while armed. That pixel is included in the frame.
  - The frame is a hit when final pix_cnt ≥ MIN_PIXELS; otherwise it is a miss.
  - armed clears at frame end.
  - A frame end seen while not armed is ignored: no frame_done, no state change.
- **State machine (advances only at a frame evaluation):**
  - SEARCH: hit → ACQUIRE with run=1, or straight to LOCKED if LOCK_FRAMES=1. Miss → stay.
  - ACQUIRE: hit → run+1; when run reaches LOCK_FRAMES → LOCKED. Miss → SEARCH, run=0.
  - LOCKED: hit → stay. Miss → COAST with miss=1, or straight to SEARCH if LOST_FRAMES=1.
  - COAST: hit → LOCKED, miss=0. Miss → miss+1; when miss reaches LOST_FRAMES → SEARCH.
- **Box outputs:**
  - Loaded from the frame bounds on every hit frame whose next state is LOCKED.
  - Held unchanged in COAST.
  - Left unchanged on entry to SEARCH.
  - box_valid = 1 exactly when track_state is LOCKED or COAST.
- A frame start arriving before the previous frame end (short frame) discards the partial frame: accumulators restart, no evaluation occurs.

## Timing
- Reset values:
  - box_valid=0, box_x0=box_x1=0, box_y0=box_y1=0.
  - frame_done=0, track_state=SEARCH(0).
  - armed=0, run=miss=0, accumulators cleared.
- Reset mid-frame: everything returns to the reset values, and accumulation resumes only at the next (0,0) pixel. The interrupted frame is never evaluated.
- Accumulator update: registered, 1 cycle after each qualified pixel.
- Frame end at cycle N: final pix_cnt and bounds are visible internally at N+1. At N+2 frame_done=1 for exactly one cycle, and track_state and the box outputs update in that same cycle.
- Back-to-back frames: a frame start may follow the frame-end pixel at N+1. Evaluation uses snapshot registers, so accumulation of the new frame must not corrupt the pending evaluation.
- The box outputs change only on frame_done cycles, so the renderer sees constant coordinates for the whole of a frame.

## Test plan
- **Reset defaults:** rst for 3 cycles, then 2 empty frames → box_valid=0, track_state=0, and frame_done pulses exactly twice, each 1 cycle wide.
- **Lock:** a 10×10 mask square at x=100..109, y=50..59 (100 px) for 2 frames → state goes 0→1→2. After frame 2, box=(100,109,50,59) and box_valid=1 in the frame_done cycle.
- **Hit threshold:** 63 mask pixels in a frame → miss. 64 pixels, including a mask pixel at (319,239) → hit.
- **Coast then drop:** after LOCKED, 3 empty frames → COAST with box held and box_valid=1. A 4th empty frame → SEARCH, box_valid=0.
- **Recover and move:** in COAST after 2 misses, a square at x=200..209 → LOCKED, box updated to x0=200, x1=209, miss counter cleared.
- **Interrupted frames:**
  - rst asserted at line 120 of a frame holding 100 mask pixels → no evaluation of that frame, state=SEARCH.
  - A short frame (restart at (0,0) on line 100) → no frame_done for the partial frame.
